tristate_bus_reader: RTL and testbench

- Reads a shared WIDTH-bit tristate bus driven by NUM_SRC 8-bit tristate buffer banks, one bank per source.
- Each bank is enabled by one of this block's E bits.
- Arbitrates round-robin among requesting sources and drives a one-hot enable to the winner. Waits for the bus to settle, captures the byte, acknowledges the source, and releases the bus with a turnaround cycle.
- Presents captured bytes on a valid/ready output register.

---
 rtl/tristate_bus_reader.sv | 140 ++++++++++++++
 tb/tb_tristate_bus_reader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tristate_bus_reader.sv
// rtl/tristate_bus_reader.sv - round-robin reader of a shared tristate bus with settle, capture and turnaround
module tristate_bus_reader #(
    parameter  int WIDTH   = 8,
    parameter  int NUM_SRC = 4,
    parameter  int SETTLE  = 1,
    localparam int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_SRC-1:0] req_i,
    output logic [NUM_SRC-1:0] e_o,
    input  logic [WIDTH-1:0]   d_i,
    output logic [NUM_SRC-1:0] ack_o,
    output logic [WIDTH-1:0]   q_o,
    output logic [SRC_W-1:0]   q_src_o,
    output logic               q_valid_o,
    input  logic               q_ready_i,
    output logic               busy_o
);

    localparam int                 CNT_W     = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CNT_W-1:0]   SETTLE_C  = CNT_W'(SETTLE);
    localparam logic [SRC_W:0]     NUM_SRC_W = (SRC_W + 1)'(NUM_SRC);
    localparam logic [SRC_W-1:0]   LAST_IDX  = SRC_W'(NUM_SRC - 1);
    localparam logic [NUM_SRC-1:0] ONE_HOT0  = NUM_SRC'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t             state_q;
    logic [SRC_W-1:0]   g_q;
    logic [SRC_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_SRC-1:0] e_q;
    logic [NUM_SRC-1:0] ack_q;
    logic [WIDTH-1:0]   q_q;
    logic [SRC_W-1:0]   q_src_q;
    logic               q_valid_q;

    logic [NUM_SRC-1:0] req_rot_d;
    logic               win_found_d;
    logic [SRC_W:0]     win_off_d;
    logic [SRC_W:0]     win_sum_d;
    logic [SRC_W-1:0]   win_idx_d;
    logic [NUM_SRC-1:0] win_oh_d;
    logic               slot_free_d;
    logic               req_g_d;
    logic [SRC_W-1:0]   ptr_next_d;

    // Round-robin pick: rotate requests so the pointer sits at bit 0, take the lowest set bit
    always_comb begin
        req_rot_d   = NUM_SRC'({req_i, req_i} >> ptr_q);
        win_found_d = 1'b0;
        win_off_d   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_rot_d[i]) begin
                win_found_d = 1'b1;
                win_off_d   = (SRC_W + 1)'(i);
            end
        end
        win_sum_d = {1'b0, ptr_q} + win_off_d;
        if (win_sum_d >= NUM_SRC_W) begin
            win_sum_d = win_sum_d - NUM_SRC_W;
        end
        win_idx_d = win_sum_d[SRC_W-1:0];
        win_oh_d  = ONE_HOT0 << win_idx_d;
    end

    // Capture-side helpers: output slot availability, live request of the granted source, next pointer
    always_comb begin
        slot_free_d = !q_valid_q || q_ready_i;
        req_g_d     = req_i[g_q];
        ptr_next_d  = (g_q == LAST_IDX) ? '0 : g_q + SRC_W'(1);
    end

    // Transfer FSM with registered enable, acknowledge and output slot; reset releases the bus at once
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            g_q       <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            e_q       <= '0;
            ack_q     <= '0;
            q_q       <= '0;
            q_src_q   <= '0;
            q_valid_q <= 1'b0;
        end else begin
            ack_q <= '0;
            if (q_valid_q && q_ready_i) begin
                q_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (win_found_d) begin
                        g_q     <= win_idx_d;
                        cnt_q   <= SETTLE_C;
                        e_q     <= win_oh_d;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (!req_g_d) begin
                        // Source withdrew: release the bus, keep the pointer so it stays favoured
                        e_q     <= '0;
                        state_q <= S_TURN;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (slot_free_d) begin
                        q_q       <= d_i;
                        q_src_q   <= g_q;
                        q_valid_q <= 1'b1;
                        ack_q     <= e_q;
                        ptr_q     <= ptr_next_d;
                        e_q       <= '0;
                        state_q   <= S_TURN;
                    end
                end
                S_TURN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    e_q     <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign e_o       = e_q;
    assign ack_o     = ack_q;
    assign q_o       = q_q;
    assign q_src_o   = q_src_q;
    assign q_valid_o = q_valid_q;
    assign busy_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_tristate_bus_reader.sv
// tb/tb_tristate_bus_reader.sv - directed and randomized checks of tristate_bus_reader
module tb_tristate_bus_reader;

    logic clk;
    logic rst_n;

    logic [3:0] req_a, e_a, ack_a;
    logic [7:0] d_a, q_a;
    logic [1:0] qsrc_a;
    logic       qv_a, qr_a, busy_a;
    logic [7:0] byte_a [4];

    logic [2:0] req_b, e_b, ack_b;
    logic [7:0] d_b, q_b;
    logic [1:0] qsrc_b;
    logic       qv_b, qr_b, busy_b;
    logic [7:0] byte_b [3];

    int total = 0;
    int bad   = 0;
    logic [3:0] prev_e_a = '0;
    logic [2:0] prev_e_b = '0;

    logic [7:0] mem [4][8];
    int         len [4];
    int         pos [4];
    logic [7:0] exp_d [$];
    int         exp_s [$];
    int         wrap_src [3] = '{2, 0, 2};
    logic [7:0] wrap_dat [3] = '{8'h62, 8'h63, 8'h62};

    tristate_bus_reader u_dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req_a), .e_o(e_a), .d_i(d_a),
        .ack_o(ack_a), .q_o(q_a), .q_src_o(qsrc_a), .q_valid_o(qv_a),
        .q_ready_i(qr_a), .busy_o(busy_a)
    );

    tristate_bus_reader #(.WIDTH(8), .NUM_SRC(3), .SETTLE(3)) u_dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req_b), .e_o(e_b), .d_i(d_b),
        .ack_o(ack_b), .q_o(q_b), .q_src_o(qsrc_b), .q_valid_o(qv_b),
        .q_ready_i(qr_b), .busy_o(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus model: the enabled source drives its byte, otherwise junk
    always_comb begin
        d_a = 8'hEE;
        for (int i = 0; i < 4; i++) if (e_a[i]) d_a = byte_a[i];
        d_b = 8'hEE;
        for (int i = 0; i < 3; i++) if (e_b[i]) d_b = byte_b[i];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        chk("a_e_onehot0", 32'($onehot0(e_a)), 32'd1);
        chk("b_e_onehot0", 32'($onehot0(e_b)), 32'd1);
        if (e_a != 0 && prev_e_a != 0) chk("a_e_gap", 32'(e_a), 32'(prev_e_a));
        if (e_b != 0 && prev_e_b != 0) chk("b_e_gap", 32'(e_b), 32'(prev_e_b));
        if (e_a != 0) chk("a_busy_e", 32'(busy_a), 32'd1);
        if (e_b != 0) chk("b_busy_e", 32'(busy_b), 32'd1);
        if (ack_a != 0) begin
            chk("a_ack_valid", 32'(qv_a), 32'd1);
            chk("a_ack_src", 32'(ack_a), 32'(4'b0001 << qsrc_a));
        end
        if (ack_b != 0) begin
            chk("b_ack_valid", 32'(qv_b), 32'd1);
            chk("b_ack_src", 32'(ack_b), 32'(3'b001 << qsrc_b));
        end
        prev_e_a = e_a;
        prev_e_b = e_b;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_e"}, 32'(e_a), 32'd0);
        chk({tag, "_ack"}, 32'(ack_a), 32'd0);
        chk({tag, "_q"}, 32'(q_a), 32'd0);
        chk({tag, "_qsrc"}, 32'(qsrc_a), 32'd0);
        chk({tag, "_qv"}, 32'(qv_a), 32'd0);
        chk({tag, "_busy"}, 32'(busy_a), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        chk_reset_a("rst_a");
        chk("rst_b_e", 32'(e_b), 32'd0);
        chk("rst_b_qv", 32'(qv_b), 32'd0);
        chk("rst_b_busy", 32'(busy_b), 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic wait_ack_a(input int lim);
        int n = 0;
        while (ack_a == 0 && n < lim) begin cyc(); n++; end
        chk("a_ack_timeout", 32'(ack_a != 0), 32'd1);
    endtask

    task automatic wait_ack_b(input int lim);
        int n = 0;
        while (ack_b == 0 && n < lim) begin cyc(); n++; end
        chk("b_ack_timeout", 32'(ack_b != 0), 32'd1);
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((busy_a || busy_b) && n < lim) begin cyc(); n++; end
        chk("idle_timeout", 32'(busy_a || busy_b), 32'd0);
    endtask

    task automatic apply_src();
        for (int i = 0; i < 4; i++) begin
            req_a[i]  = (pos[i] < len[i]);
            byte_a[i] = (pos[i] < len[i]) ? mem[i][pos[i]] : 8'hEE;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_a = '0; qr_a = 1'b1;
        req_b = '0; qr_b = 1'b1;
        for (int i = 0; i < 4; i++) byte_a[i] = 8'h00;
        for (int i = 0; i < 3; i++) byte_b[i] = 8'h00;
        @(negedge clk);
        do_reset();

        // single source, SETTLE=1
        byte_a[1] = 8'hA5; req_a = 4'b0010;
        cyc();
        chk("single_e_c1", 32'(e_a), 32'h2);
        chk("single_busy_c1", 32'(busy_a), 32'd1);
        cyc();
        chk("single_e_c2", 32'(e_a), 32'h2);
        chk("single_ack_c2", 32'(ack_a), 32'd0);
        cyc();
        chk("single_e_c3", 32'(e_a), 32'd0);
        chk("single_q", 32'(q_a), 32'hA5);
        chk("single_qsrc", 32'(qsrc_a), 32'd1);
        chk("single_qv", 32'(qv_a), 32'd1);
        chk("single_ack", 32'(ack_a), 32'h2);
        req_a = 4'b0000;
        cyc();
        chk("single_ack_c4", 32'(ack_a), 32'd0);
        chk("single_qv_c4", 32'(qv_a), 32'd0);
        chk("single_busy_c4", 32'(busy_a), 32'd0);

        // round-robin, all sources requesting
        do_reset();
        for (int i = 0; i < 4; i++) byte_a[i] = 8'h10 + 8'(i);
        req_a = 4'b1111; qr_a = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_ack_a(20);
            chk("rr_q", 32'(q_a), 32'h10 + 32'(k % 4));
            chk("rr_qsrc", 32'(qsrc_a), 32'(k % 4));
            cyc();
        end
        req_a = 4'b0000;
        wait_idle(20);

        // backpressure on source 2
        byte_a[2] = 8'h5C; req_a = 4'b0100; qr_a = 1'b0;
        wait_ack_a(20);
        chk("bp_q0", 32'(q_a), 32'h5C);
        chk("bp_qsrc0", 32'(qsrc_a), 32'd2);
        byte_a[2] = 8'h3B;
        repeat (6) cyc();
        chk("bp_e_held", 32'(e_a), 32'h4);
        chk("bp_no_ack", 32'(ack_a), 32'd0);
        chk("bp_qv_held", 32'(qv_a), 32'd1);
        chk("bp_q_stable", 32'(q_a), 32'h5C);
        qr_a = 1'b1;
        cyc();
        chk("bp_ack", 32'(ack_a), 32'h4);
        chk("bp_qv_stay", 32'(qv_a), 32'd1);
        chk("bp_q1", 32'(q_a), 32'h3B);
        chk("bp_qsrc1", 32'(qsrc_a), 32'd2);
        chk("bp_e_turn", 32'(e_a), 32'd0);
        req_a = 4'b0000;
        cyc();
        chk("bp_qv_drain", 32'(qv_a), 32'd0);

        // withdraw on the 3-source, SETTLE=3 instance
        byte_b[0] = 8'h61; req_b = 3'b001; qr_b = 1'b0;
        wait_ack_b(30);
        chk("wd_q0", 32'(q_b), 32'h61);
        chk("wd_qsrc0", 32'(qsrc_b), 32'd0);
        req_b = 3'b000;
        cyc();
        cyc();
        byte_b[2] = 8'h62; req_b = 3'b100;
        cyc();
        chk("wd_e_g1", 32'(e_b), 32'h4);
        cyc();
        chk("wd_e_g2", 32'(e_b), 32'h4);
        req_b = 3'b000;
        cyc();
        chk("wd_e_drop", 32'(e_b), 32'd0);
        chk("wd_no_ack", 32'(ack_b), 32'd0);
        chk("wd_qv_keep", 32'(qv_b), 32'd1);
        chk("wd_q_keep", 32'(q_b), 32'h61);
        cyc();

        // pointer still at 1 after the withdraw: grants go 2, 0, 2
        byte_b[0] = 8'h63; req_b = 3'b101; qr_b = 1'b1;
        cyc();
        chk("wrap_first_e", 32'(e_b), 32'h4);
        for (int k = 0; k < 3; k++) begin
            wait_ack_b(30);
            chk("wrap_qsrc", 32'(qsrc_b), 32'(wrap_src[k]));
            chk("wrap_q", 32'(q_b), 32'(wrap_dat[k]));
            chk("wrap_qsrc_range", 32'(qsrc_b < 2'd3), 32'd1);
            cyc();
        end
        req_b = 3'b000;
        wait_idle(30);

        // asynchronous reset while granted
        byte_a[0] = 8'h77; req_a = 4'b0001; qr_a = 1'b0;
        cyc();
        chk("ar_e_granted", 32'(e_a), 32'h1);
        #2 rst_n = 1'b0;
        #1 chk_reset_a("ar_async");
        cyc();
        chk_reset_a("ar_held");
        byte_a[0] = 8'h99; qr_a = 1'b1;
        rst_n = 1'b1;
        wait_ack_a(20);
        chk("ar_after_q", 32'(q_a), 32'h99);
        chk("ar_after_qsrc", 32'(qsrc_a), 32'd0);
        req_a = 4'b0000;
        wait_idle(20);

        // randomized traffic against a transaction-level round-robin model
        for (int r = 0; r < 3; r++) begin
            int ptr;
            int tp [4];
            int remaining;
            int n;
            do_reset();
            remaining = 0;
            for (int i = 0; i < 4; i++) begin
                len[i] = int'($urandom_range(0, 6));
                pos[i] = 0;
                tp[i]  = 0;
                remaining += len[i];
                for (int k = 0; k < 8; k++) mem[i][k] = 8'($urandom);
            end
            ptr = 0;
            while (remaining > 0) begin
                for (int off = 0; off < 4; off++) begin
                    int s;
                    s = (ptr + off) % 4;
                    if (tp[s] < len[s]) begin
                        exp_d.push_back(mem[s][tp[s]]);
                        exp_s.push_back(s);
                        tp[s]++;
                        remaining--;
                        ptr = (s + 1) % 4;
                        break;
                    end
                end
            end
            apply_src();
            qr_a = 1'b0;
            n = 0;
            while (exp_d.size() > 0 && n < 3000) begin
                cyc();
                n++;
                if (ack_a != 0) begin
                    for (int i = 0; i < 4; i++) if (ack_a[i]) pos[i]++;
                    apply_src();
                end
                qr_a = 1'($urandom_range(0, 1));
                if (qv_a && qr_a) begin
                    chk("rand_q", 32'(q_a), 32'(exp_d[0]));
                    chk("rand_qsrc", 32'(qsrc_a), 32'(exp_s[0]));
                    void'(exp_d.pop_front());
                    void'(exp_s.pop_front());
                end
            end
            chk("rand_drain", 32'(exp_d.size()), 32'd0);
            exp_d.delete();
            exp_s.delete();
            req_a = 4'b0000;
            qr_a = 1'b1;
            wait_idle(40);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
